// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver state encoding, parity codes and baud divisor helper
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-flop RX synchroniser with falling-edge detect
module uart_rx_sync (
  input  logic CLK,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);

  logic       meta_q, meta_d;
  logic       sync_q, sync_d;
  logic       prev_q, prev_d;
  logic [1:0] fill_q, fill_d;
  logic       armed_q, armed_d;

  // Edges are only trusted once a genuine high has passed through the chain,
  // so a line that is already low when reset releases never looks like a start.
  always_comb begin
    meta_d  = rx;
    sync_d  = meta_q;
    prev_d  = sync_q;
    fill_d  = {fill_q[0], 1'b1};
    armed_d = armed_q | (fill_q[1] & sync_q);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
    end
  end

  assign rx_s    = sync_q;
  assign rx_fall = armed_q & prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: start, LSB-first data, parity, stop; mid-bit sampling.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote over mid-1/mid/mid+1 samples.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_RATE      = 115200,
  parameter int CLK_FREQ       = 10_000_000,
  parameter int VLD_DATA_WIDTH = 8,
  parameter int CHECK_SEL      = 1
) (
  input  logic                      CLK,
  input  logic                      rst_n,
  input  logic                      RX,
  output logic [VLD_DATA_WIDTH-1:0] dout,
  output logic                      dout_vld,
  output logic                      parity_err,
  output logic                      frame_err,
  output logic                      RX_busy
);

  localparam int BAUD_CNT = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int HALF_CNT = BAUD_CNT / 2;
  localparam int CW       = $clog2(BAUD_CNT);
  localparam int BW       = $clog2(VLD_DATA_WIDTH + 1);
`ifdef UART_RX_MAJORITY_EN
  localparam int START_LAST = HALF_CNT;
`else
  localparam int START_LAST = HALF_CNT - 1;
`endif
  localparam logic [CW-1:0] START_END = CW'(START_LAST);
  localparam logic [CW-1:0] BIT_END   = CW'(BAUD_CNT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(VLD_DATA_WIDTH - 1);
  localparam logic          PAR_SEL   = (CHECK_SEL != 0) ? PARITY_ODD : PARITY_EVEN;

  logic rx_s, rx_fall, bit_val;

  uart_rx_sync u_sync (
    .CLK    (CLK),
    .rst_n  (rst_n),
    .rx     (RX),
    .rx_s   (rx_s),
    .rx_fall(rx_fall)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q, hist_d;

  always_comb hist_d = {hist_q[0], rx_s};

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) hist_q <= 2'b11;
    else        hist_q <= hist_d;
  end

  assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  rx_state_t                 state_q, state_d;
  logic [CW-1:0]             baud_cnt_q, baud_cnt_d;
  logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
  logic [VLD_DATA_WIDTH-1:0] shift_q, shift_d;
  logic [VLD_DATA_WIDTH-1:0] dout_q, dout_d;
  logic                      par_pend_q, par_pend_d;
  logic                      dout_vld_q, dout_vld_d;
  logic                      parity_err_q, parity_err_d;
  logic                      frame_err_q, frame_err_d;
  logic                      busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    baud_cnt_d   = baud_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    dout_d       = dout_q;
    par_pend_d   = par_pend_q;
    dout_vld_d   = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        if (rx_fall) begin
          state_d    = START;
          baud_cnt_d = '0;
          busy_d     = 1'b1;
        end
      end
      START: begin
        if (baud_cnt_q == START_END) begin
          if (!bit_val) begin
            state_d    = DATA;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_cnt_q == BIT_END) begin
          baud_cnt_d = '0;
          shift_d    = {bit_val, shift_q[VLD_DATA_WIDTH-1:1]};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) state_d = PARITY;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (baud_cnt_q == BIT_END) begin
          baud_cnt_d = '0;
          par_pend_d = ((^shift_q) ^ bit_val) != PAR_SEL;
          state_d    = STOP;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      STOP: begin
        // Returning to IDLE at mid-stop lets a back-to-back start edge be caught.
        if (baud_cnt_q == BIT_END) begin
          baud_cnt_d   = '0;
          dout_d       = shift_q;
          parity_err_d = par_pend_q;
          frame_err_d  = ~bit_val;
          dout_vld_d   = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      baud_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      dout_q       <= '0;
      par_pend_q   <= 1'b0;
      dout_vld_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      dout_q       <= dout_d;
      par_pend_q   <= par_pend_d;
      dout_vld_q   <= dout_vld_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign dout       = dout_q;
  assign dout_vld   = dout_vld_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign RX_busy    = busy_q;

endmodule
